vending_machine_multi: RTL and testbench
========================================

Name: vending_machine_multi

Overview:
- Parametrised successor to the single-product 5/10 rs vending FSM.
- Handles N_PROD products, each with its own price, and three coin denominations (5/10/20 rs).
- Keeps a running credit; returns change over a ready/valid coin handshake; supports cancel-and-refund.
- Sits between the coin acceptor front end and the dispenser/change-hopper drivers.

Parameters:
- N_PROD, 4, number of selectable products (2..16).
- CREDIT_W, 8, credit accumulator width, in 5 rs units.
- PRICES, {8'd8,8'd5,8'd4,8'd3}, packed N_PROD x CREDIT_W price table in 5 rs units; product 0 is in the LSBs.
- MAX_CREDIT, 20, credit ceiling in units; coins that would exceed it are rejected.
- TIMEOUT_CYC, 1000, idle cycles before auto-refund (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- coin  in  2  00 none, 01 = 5 rs (1 unit), 10 = 10 rs (2 units), 11 = 20 rs (4 units); sampled every cycle.
- sel_valid  in  1  product selection strobe.
- sel_id  in  $clog2(N_PROD)  selected product.
- cancel  in  1  refund request.
- coin_reject  out  1  one-cycle pulse: the coin this cycle was not accepted.
- short_credit  out  1  one-cycle pulse: selection refused because credit < price.
- vend  out  1  one-cycle dispense pulse.
- vend_id  out  $clog2(N_PROD)  product being dispensed; valid with vend.
- change_valid  out  1  change coin presented.
- change_coin  out  2  01 = 5 rs, 10 = 10 rs; held stable while change_valid and not change_ready.
- change_ready  in  1  hopper accepts the presented coin.
- credit  out  CREDIT_W  current credit in units.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; credit = 0.
  - All outputs are 0.
  - Reset mid-CHANGE drops any remaining change without dispensing it.
- All outputs are registered. Responses appear one cycle after the input sample.
- States: IDLE (credit 0), CREDIT (credit > 0), VEND, CHANGE.
- Priority in IDLE/CREDIT: cancel > sel_valid > coin.
  - A coin arriving alongside a higher-priority event is rejected with coin_reject.
- Coin accept: credit += value, provided credit + value <= MAX_CREDIT.
  - Otherwise: coin_reject, credit unchanged.
  - IDLE goes to CREDIT on the first accepted coin.
- Select in IDLE/CREDIT:
  - sel_id >= N_PROD: short_credit pulse, no state change.
  - price = PRICES[sel_id]. If credit >= price: go to VEND.
  - Otherwise: short_credit pulse, stay in the current state.
- VEND (exactly one cycle):
  - vend=1, vend_id=sel_id latched; credit -= price.
  - Next state: CHANGE if the remainder > 0, else IDLE.
- cancel in CREDIT: go to CHANGE with the full credit (no vend).
- cancel in IDLE: ignored.
- CHANGE:
  - Each coin: 10 rs if remaining >= 2 units, else 5 rs.
  - Coin transfers when change_valid && change_ready; credit decrements by the coin value in that cycle.
  - change_valid drops and state goes to IDLE in the cycle after credit reaches 0.
  - Back-to-back transfers: one coin per cycle if change_ready is held high.
- In VEND/CHANGE: every nonzero coin gets coin_reject; sel_valid and cancel are ignored.
- Arithmetic: unsigned CREDIT_W.
  - MAX_CREDIT + 4 must fit in CREDIT_W; elaboration fails otherwise.
  - No wrap is possible by construction.

Optional Feature:
- Macro: VENDING_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in CREDIT and clears on any accepted coin or selection attempt.
  - When the counter reaches TIMEOUT_CYC, the block enters CHANGE and refunds the full credit, exactly as for cancel.
  - Extra output timeout_refund (1 bit) pulses for one cycle at entry to CHANGE.
- Undefined: no counter, no timeout_refund port; credit is held indefinitely.

Decomposition:
- Package vending_pkg:
  - state enum (S_IDLE, S_CREDIT, S_VEND, S_CHANGE);
  - coin encodings (COIN_NONE, COIN_5, COIN_10, COIN_20);
  - change encodings (CHG_5, CHG_10);
  - function coin_units() mapping encoding to units.
- Sub-module vending_change_dispenser:
  - loaded with the amount to return;
  - runs the change_valid/change_ready handshake and the greedy 10/5 selection;
  - returns done and the remaining amount.
- The top level keeps the credit FSM and the price lookup.

Test Plan:
- Coins 10, 5 (credit 3); select product 0 (price 3) -> vend=1, vend_id=0, credit 0, IDLE, no change_valid.
- Coins 20, 20 (credit 8); select product 1 (price 4) -> vend; change 10, 10 with change_ready held high, on consecutive cycles; IDLE.
- Credit 3; select product 3 (price 8) -> short_credit pulse, credit stays 3. Then cancel with change_ready low for 3 cycles -> change_coin=10 held stable; release ready -> 10 then 5, credit 0.
- Credit 18; insert 20 -> coin_reject, credit 18. Insert 10 -> credit 20.
- Coin during CHANGE, and coin with sel_valid in the same cycle -> coin_reject each time, credit unaffected. Assert rst low mid-CHANGE -> all outputs 0 immediately, credit 0.
- VENDING_TIMEOUT_EN, TIMEOUT_CYC=10: insert 5, idle 10 cycles -> timeout_refund pulse, change 5, IDLE.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and encodings for the multi-product vending controller:
// FSM states, coin/change encodings and the coin-to-units mapping.
package vending_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CREDIT = 2'b01,
    S_VEND   = 2'b10,
    S_CHANGE = 2'b11
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam logic [1:0] CHG_5  = 2'b01;
  localparam logic [1:0] CHG_10 = 2'b10;

  // Change encodings share the coin encodings, so this also sizes change coins.
  function automatic logic [2:0] coin_units(input logic [1:0] c);
    case (c)
      COIN_5:  return 3'd1;
      COIN_10: return 3'd2;
      COIN_20: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_change_dispenser.sv
// Change hopper driver: loaded with an amount in 5 rs units, pays it out greedily
// (10 rs while >= 2 units remain, else 5 rs) over a change_valid/change_ready handshake.
module vending_change_dispenser
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_amt,
  input  logic                change_ready,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic [CREDIT_W-1:0] remaining,
  output logic                done
);

  logic [CREDIT_W-1:0] rem_q, rem_d, rem_after_s;
  logic                valid_q, valid_d;
  logic [1:0]          coin_q, coin_d;
  logic                xfer_s;

  function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] amt);
    if (amt == '0) begin
      return COIN_NONE;
    end else if (amt >= CREDIT_W'(2)) begin
      return CHG_10;
    end else begin
      return CHG_5;
    end
  endfunction

  assign xfer_s      = valid_q && change_ready;
  assign rem_after_s = rem_q - CREDIT_W'(coin_units(coin_q));

  // Next remaining amount and the coin to present for it.
  always_comb begin
    rem_d = rem_q;
    if (load) begin
      rem_d = load_amt;
    end else if (xfer_s) begin
      rem_d = rem_after_s;
    end else begin
      rem_d = rem_q;
    end
    valid_d = (rem_d != '0);
    coin_d  = pick_coin(rem_d);
  end

  // Handshake state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q   <= '0;
      valid_q <= 1'b0;
      coin_q  <= COIN_NONE;
    end else begin
      rem_q   <= rem_d;
      valid_q <= valid_d;
      coin_q  <= coin_d;
    end
  end

  assign change_valid = valid_q;
  assign change_coin  = coin_q;
  assign remaining    = rem_q;
  assign done         = xfer_s && (rem_after_s == '0);

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: credit FSM, price lookup and change return.
// Define VENDING_TIMEOUT_EN to add the idle auto-refund and the timeout_refund output.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int                          N_PROD      = 4,
  parameter int                          CREDIT_W    = 8,
  parameter logic [N_PROD*CREDIT_W-1:0]  PRICES      = {8'd8, 8'd5, 8'd4, 8'd3},
  parameter int                          MAX_CREDIT  = 20,
  parameter int                          TIMEOUT_CYC = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                coin,
  input  logic                      sel_valid,
  input  logic [$clog2(N_PROD)-1:0] sel_id,
  input  logic                      cancel,
  output logic                      coin_reject,
  output logic                      short_credit,
  output logic                      vend,
  output logic [$clog2(N_PROD)-1:0] vend_id,
  output logic                      change_valid,
  output logic [1:0]                change_coin,
  input  logic                      change_ready,
  output logic [CREDIT_W-1:0]       credit,
  output logic                      busy
`ifdef VENDING_TIMEOUT_EN
  ,
  output logic                      timeout_refund
`endif
);

  localparam int SEL_W = $clog2(N_PROD);
  localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);

  if (N_PROD < 2 || N_PROD > 16) begin : g_bad_nprod
    $error("vending_machine_multi: N_PROD must be 2..16");
  end
  if (MAX_CREDIT + 4 >= (1 << CREDIT_W)) begin : g_bad_width
    $error("vending_machine_multi: MAX_CREDIT + 4 does not fit in CREDIT_W");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("vending_machine_multi: TIMEOUT_CYC must be >= 1");
  end

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coin_reject_q, coin_reject_d;
  logic                short_credit_q, short_credit_d;
  logic                vend_q, vend_d;
  logic [SEL_W-1:0]    vend_id_q, vend_id_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W-1:0] price_s, sum_s, chg_rem_s;
  logic                sel_ok_s, coin_ok_s, load_s, chg_done_s, xfer_s;

`ifdef VENDING_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_refund_q, timeout_refund_d;
`endif

  vending_change_dispenser #(.CREDIT_W(CREDIT_W)) u_change (
    .clk          (clk),
    .rst          (rst),
    .load         (load_s),
    .load_amt     (credit_q),
    .change_ready (change_ready),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .remaining    (chg_rem_s),
    .done         (chg_done_s)
  );

  // Price lookup and coin headroom for the current inputs.
  always_comb begin
    price_s = '0;
    for (int i = 0; i < N_PROD; i++) begin
      price_s = (int'(sel_id) == i) ? PRICES[i*CREDIT_W +: CREDIT_W] : price_s;
    end
    sel_ok_s  = (int'(sel_id) < N_PROD);
    sum_s     = credit_q + CREDIT_W'(coin_units(coin));
    coin_ok_s = (coin != COIN_NONE) && (sum_s <= MAX_C);
    xfer_s    = change_valid && change_ready;
  end

  // Credit FSM next state; priority in IDLE/CREDIT is cancel > select > coin.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    coin_reject_d  = 1'b0;
    short_credit_d = 1'b0;
    vend_d         = 1'b0;
    vend_id_d      = '0;
    load_s         = 1'b0;
    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (cancel && (state_q == S_CREDIT)) begin
          coin_reject_d = (coin != COIN_NONE);
          state_d       = S_CHANGE;
          load_s        = 1'b1;
        end else if (sel_valid) begin
          coin_reject_d = (coin != COIN_NONE);
          if (sel_ok_s && (credit_q >= price_s)) begin
            state_d   = S_VEND;
            credit_d  = credit_q - price_s;
            vend_d    = 1'b1;
            vend_id_d = sel_id;
          end else begin
            short_credit_d = 1'b1;
          end
        end else if (coin != COIN_NONE) begin
          if (coin_ok_s) begin
            credit_d = sum_s;
            state_d  = S_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_VEND: begin
        coin_reject_d = (coin != COIN_NONE);
        if (credit_q != '0) begin
          state_d = S_CHANGE;
          load_s  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHANGE: begin
        coin_reject_d = (coin != COIN_NONE);
        if (chg_done_s) begin
          state_d  = S_IDLE;
          credit_d = '0;
        end else if (xfer_s) begin
          credit_d = chg_rem_s - CREDIT_W'(coin_units(change_coin));
        end else begin
          credit_d = credit_q;
        end
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase

`ifdef VENDING_TIMEOUT_EN
    // Idle cycles in CREDIT without an accepted coin or selection count toward refund.
    timeout_refund_d = 1'b0;
    tmo_cnt_d        = '0;
    if ((state_q == S_CREDIT) && !cancel && !sel_valid && !coin_ok_s) begin
      if (tmo_cnt_q == TMO_LAST) begin
        state_d          = S_CHANGE;
        load_s           = 1'b1;
        timeout_refund_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end else begin
      tmo_cnt_d = '0;
    end
`endif

    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      coin_reject_q  <= 1'b0;
      short_credit_q <= 1'b0;
      vend_q         <= 1'b0;
      vend_id_q      <= '0;
      busy_q         <= 1'b0;
`ifdef VENDING_TIMEOUT_EN
      tmo_cnt_q        <= '0;
      timeout_refund_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      coin_reject_q  <= coin_reject_d;
      short_credit_q <= short_credit_d;
      vend_q         <= vend_d;
      vend_id_q      <= vend_id_d;
      busy_q         <= busy_d;
`ifdef VENDING_TIMEOUT_EN
      tmo_cnt_q        <= tmo_cnt_d;
      timeout_refund_q <= timeout_refund_d;
`endif
    end
  end

  assign coin_reject  = coin_reject_q;
  assign short_credit = short_credit_q;
  assign vend         = vend_q;
  assign vend_id      = vend_id_q;
  assign credit       = credit_q;
  assign busy         = busy_q;
`ifdef VENDING_TIMEOUT_EN
  assign timeout_refund = timeout_refund_q;
`endif

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios plus random traffic against a
// transaction-level model (credit count plus a queue of pending change coins).
module tb_vending_machine_multi;

  localparam int N_PROD      = 4;
  localparam int CREDIT_W    = 8;
  localparam int MAX_CREDIT  = 20;
  localparam int TIMEOUT_CYC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = 2'b00;
  logic       cancel = 1'b0;
  logic       change_ready = 1'b0;
  logic       coin_reject, short_credit, vend, change_valid, busy;
  logic [1:0] vend_id, change_coin;
  logic [CREDIT_W-1:0] credit;
`ifdef VENDING_TIMEOUT_EN
  logic       timeout_refund;
`endif

  vending_machine_multi #(
    .N_PROD(N_PROD), .CREDIT_W(CREDIT_W), .PRICES({8'd8, 8'd5, 8'd4, 8'd3}),
    .MAX_CREDIT(MAX_CREDIT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .coin(coin), .sel_valid(sel_valid), .sel_id(sel_id),
    .cancel(cancel), .coin_reject(coin_reject), .short_credit(short_credit),
    .vend(vend), .vend_id(vend_id), .change_valid(change_valid),
    .change_coin(change_coin), .change_ready(change_ready), .credit(credit),
    .busy(busy)
`ifdef VENDING_TIMEOUT_EN
    , .timeout_refund(timeout_refund)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int price_tab[N_PROD] = '{3, 4, 5, 8};

  // Reference model state
  int m_credit;
  bit m_vend;
  int m_vid;
  int m_q[$];
  int m_idle;
  bit e_reject, e_short, e_vend, e_tmo;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_vend = 0; m_vid = 0; m_idle = 0; m_q.delete();
    e_reject = 0; e_short = 0; e_vend = 0; e_tmo = 0;
  endtask

  task automatic fill_change(input int amt);
    for (int i = 0; i < amt / 2; i++) m_q.push_back(2);
    if (amt % 2 == 1) m_q.push_back(1);
  endtask

  task automatic model_step(input logic [1:0] c, input bit sv, input int sid,
                            input bit cn, input bit rdy);
    int  units;
    bit  accepted;
    bit  was_credit;
    units = (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : (c == 2'd3) ? 4 : 0;
    e_reject = 0; e_short = 0; e_vend = 0; e_tmo = 0;
    accepted = 0;
    if (m_vend) begin
      e_reject = (units > 0);
      m_vend = 0;
      fill_change(m_credit);
    end else if (m_q.size() > 0) begin
      e_reject = (units > 0);
      if (rdy) begin
        m_credit -= m_q[0];
        void'(m_q.pop_front());
      end
    end else begin
      was_credit = (m_credit > 0);
      if (cn && m_credit > 0) begin
        e_reject = (units > 0);
        fill_change(m_credit);
      end else if (sv) begin
        e_reject = (units > 0);
        if (sid < N_PROD && m_credit >= price_tab[sid]) begin
          m_credit -= price_tab[sid];
          m_vend = 1; e_vend = 1; m_vid = sid;
        end else begin
          e_short = 1;
        end
      end else if (units > 0) begin
        if (m_credit + units <= MAX_CREDIT) begin
          m_credit += units;
          accepted = 1;
        end else begin
          e_reject = 1;
        end
      end
`ifdef VENDING_TIMEOUT_EN
      if (was_credit && !cn && !sv && !accepted) begin
        m_idle++;
        if (m_idle == TIMEOUT_CYC) begin
          fill_change(m_credit);
          e_tmo = 1;
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
`else
      if (was_credit && accepted) m_idle = 0;
`endif
    end
  endtask

  task automatic compare_all();
    check_eq("coin_reject", coin_reject, e_reject);
    check_eq("short_credit", short_credit, e_short);
    check_eq("vend", vend, e_vend);
    if (e_vend) check_eq("vend_id", vend_id, m_vid);
    check_eq("change_valid", change_valid, m_q.size() > 0);
    check_eq("change_coin", change_coin,
             (m_q.size() == 0) ? 0 : ((m_q[0] == 2) ? 2 : 1));
    check_eq("credit", credit, m_credit);
    check_eq("busy", busy, m_vend || (m_q.size() > 0));
`ifdef VENDING_TIMEOUT_EN
    check_eq("timeout_refund", timeout_refund, e_tmo);
`endif
  endtask

  task automatic tick(input logic [1:0] c, input bit sv, input int sid,
                      input bit cn, input bit rdy);
    @(negedge clk);
    coin = c; sel_valid = sv; sel_id = sid[1:0]; cancel = cn; change_ready = rdy;
    @(posedge clk);
    model_step(c, sv, sid, cn, rdy);
    #1;
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             {24'd0, coin_reject, short_credit, vend, vend_id, change_valid, change_coin, busy},
             32'd0);
    check_eq({tag, "_credit"}, credit, 32'd0);
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Exact price, no change
    tick(2'd2, 0, 0, 0, 1);
    tick(2'd1, 0, 0, 0, 1);
    tick(2'd0, 1, 0, 0, 1);
    check_eq("t1_vend", vend, 32'd1);
    check_eq("t1_credit", credit, 32'd0);
    tick(2'd0, 0, 0, 0, 1);
    check_eq("t1_no_change", change_valid, 32'd0);

    // Change 10,10 back to back
    tick(2'd3, 0, 0, 0, 1);
    tick(2'd3, 0, 0, 0, 1);
    tick(2'd0, 1, 1, 0, 1);
    repeat (4) tick(2'd0, 0, 0, 0, 1);
    check_eq("t2_idle", busy, 32'd0);

    // Short credit, then cancel with a stalled hopper
    tick(2'd2, 0, 0, 0, 0);
    tick(2'd1, 0, 0, 0, 0);
    tick(2'd0, 1, 3, 0, 0);
    check_eq("t3_short", short_credit, 32'd1);
    check_eq("t3_credit", credit, 32'd3);
    tick(2'd0, 0, 0, 1, 0);
    repeat (3) begin
      tick(2'd0, 0, 0, 0, 0);
      check_eq("t3_hold", change_coin, 32'd2);
    end
    repeat (3) tick(2'd0, 0, 0, 0, 1);
    check_eq("t3_done", credit, 32'd0);

    // Credit ceiling
    repeat (4) tick(2'd3, 0, 0, 0, 0);
    tick(2'd2, 0, 0, 0, 0);
    tick(2'd3, 0, 0, 0, 0);
    check_eq("t4_reject", coin_reject, 32'd1);
    check_eq("t4_credit", credit, 32'd18);
    tick(2'd2, 0, 0, 0, 0);
    check_eq("t4_max", credit, 32'd20);

    // Coins during CHANGE, then drain
    tick(2'd0, 0, 0, 1, 0);
    tick(2'd1, 0, 0, 0, 0);
    tick(2'd3, 0, 0, 0, 1);
    repeat (10) tick(2'd0, 0, 0, 0, 1);
    // Coin together with a selection
    tick(2'd1, 1, 0, 0, 0);
    check_eq("t5_sel_coin", coin_reject, 32'd1);

    // Reset mid-CHANGE
    tick(2'd3, 0, 0, 0, 0);
    tick(2'd0, 0, 0, 1, 0);
    tick(2'd0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 check_all_zero("t6_rst");
    model_reset();
    @(negedge clk);
    coin = 2'd0; sel_valid = 1'b0; cancel = 1'b0; change_ready = 1'b0;
    rst = 1'b1;

`ifdef VENDING_TIMEOUT_EN
    tick(2'd1, 0, 0, 0, 0);
    repeat (TIMEOUT_CYC) tick(2'd0, 0, 0, 0, 0);
    check_eq("t7_tmo", timeout_refund, 32'd1);
    repeat (2) tick(2'd0, 0, 0, 0, 1);
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] c;
      bit sv, cn, rdy;
      int sid;
      c   = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      sv  = ($urandom_range(0, 5) == 0);
      sid = $urandom_range(0, N_PROD - 1);
      cn  = (c == 2'd0) && ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      tick(c, sv, sid, cn, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
